mod_mul_serial: RTL and testbench
=================================

# mod_mul_serial

Bit-serial interleaved modular multiplier computing r = a·b mod p for operands up to WIDTH bits. It sits directly downstream of the binary modular inversion stage. It consumes the inverse a⁻¹ mod p and multiplies it with a further operand; feeding the original a back in gives the a·a⁻¹ ≡ 1 self-check. It processes one bit of b per clock, MSB first, using a start/done handshake.

## Interface
- WIDTH, 256, operand and modulus width in bits
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE
- a  input  WIDTH  multiplicand; captured on accepted start
- b  input  WIDTH  multiplier; captured on accepted start
- p  input  WIDTH  modulus; captured on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse, high in DONE
- result  output  WIDTH  a·b mod p; valid from done, held until the next accepted start
- err  output  1  range-check flag; valid with done (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- IDLE:
  - If start=1: capture a, b and p into registers, clear acc to 0, set cnt=WIDTH-1, then go to RUN.
  - If start=0: stay in IDLE.
- RUN, one iteration per cycle, entirely combinational within the cycle:
  - t1 = 2·acc; if t1 ≥ p then t1 −= p.
  - t2 = t1 + (b_reg[cnt] ? a_reg : 0); if t2 ≥ p then t2 −= p.
  - acc ← t2.
  - If cnt==0, go to DONE; otherwise cnt −= 1.
- Internal width: acc, t1 and t2 are WIDTH+2 bits, so no intermediate value overflows when inputs are < p. result takes the low WIDTH bits of acc.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE. start is ignored in DONE.
- start is ignored in RUN. The captured operands cannot be disturbed mid-operation.
- Input contract: p ≥ 2, a < p, b < p. Operands outside this range produce an unspecified result, but the latency is unchanged.
- b=0 or a=0 gives result=0. p is not required to be odd.

## Timing
- Reset values: busy=0, done=0, result=0, err=0, state=IDLE, acc=0, cnt=0.
- start sampled high in IDLE at edge k:
  - busy=1 during cycles k+1 … k+WIDTH.
  - done=1 and result valid in cycle k+WIDTH+1.
  - IDLE again at k+WIDTH+2.
- Latency is WIDTH+1 cycles from start to done.
- Throughput: the earliest next accepted start is in the cycle after done. Minimum period is WIDTH+2 cycles.
- result updates only on the DONE entry edge. It holds its value across IDLE and across the next RUN until that run's DONE.
- rst_n=0 mid-RUN: on the next edge, return to IDLE with all outputs at reset values. No done is produced for the aborted operation.
- A start pulse coincident with rst_n=0 is discarded.

## Configuration
- MODMUL_RANGE_CHECK_EN defined:
  - On an accepted start, if p < 2, a ≥ p or b ≥ p, go IDLE→DONE directly.
  - This gives done at k+1 with err=1 and result=0, and busy stays 0.
  - Otherwise err=0 and operation is normal.
  - err is registered and is cleared on the next accepted start.
- MODMUL_RANGE_CHECK_EN undefined: no comparators are built, err is tied to 0, and the input contract is the caller's responsibility.

## Test plan
- Small vector: WIDTH=256, a=5, b=9, p=11 → done at cycle 257 after start, result=1, err=0.
- Wide vector: p=8542D69E_4C044F18_E8B92435_BF6FF7DE_45728391_5C45517D_722EDB8B_08F1DFC3, a=b=p−1 → result=1. Then a=p−1, b=2 → result=p−2.
- Zero operand: a=0, b=p−1 (same p) → result=0. Latency is still WIDTH+1 cycles.
- Handshake:
  - Pulse start again 10 cycles into RUN, with different operands → ignored; the first result is unchanged.
  - Pulse start during DONE → ignored; busy stays 0 the next cycle.
  - Pulse start the cycle after DONE → accepted.
- Reset mid-op: drive rst_n=0 for 1 cycle at RUN cycle 100 → busy=0, done never pulses, result=0. A fresh start=1 afterwards completes normally.
- With MODMUL_RANGE_CHECK_EN: a=p (p=11, a=11, b=3) → done one cycle after start, err=1, result=0. A following valid job gives err=0.

Source files
------------

// File: rtl/mod_mul_serial.sv
// Bit-serial interleaved modular multiplier r = a*b mod p, one bit of b per clock, MSB first.
// Optional operand range check is built when MODMUL_RANGE_CHECK_EN is defined.
module mod_mul_serial #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ACC_W = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [ACC_W-1:0]   p_ext;
  logic [ACC_W-1:0]   t1;
  logic [ACC_W-1:0]   t2;

`ifdef MODMUL_RANGE_CHECK_EN
  logic err_q, err_d;
  logic bad_op;
  assign bad_op = (p < WIDTH'(2)) || (a >= p) || (b >= p);
  assign err    = err_q;
`else
  assign err = 1'b0;
`endif

  assign p_ext = {2'b00, p_q};

  // One interleaved step: double-and-reduce, then conditional add-and-reduce.
  always_comb begin
    t1 = acc_q << 1;
    if (t1 >= p_ext) t1 = t1 - p_ext;
    t2 = t1 + (b_q[cnt_q] ? {2'b00, a_q} : '0);
    if (t2 >= p_ext) t2 = t2 - p_ext;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef MODMUL_RANGE_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          p_d     = p;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = RUN;
`ifdef MODMUL_RANGE_CHECK_EN
          err_d   = 1'b0;
          if (bad_op) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = DONE;
          end
`endif
        end
      end
      RUN: begin
        acc_d = t2;
        if (cnt_q == '0) begin
          result_d = t2[WIDTH-1:0];
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef MODMUL_RANGE_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef MODMUL_RANGE_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Operand registers only change on an accepted start, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    p_q <= p_d;
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mod_mul_serial.sv
// Randomized self-checking bench for mod_mul_serial against a wide-arithmetic a*b mod p model.
module tb_mod_mul_serial;
  localparam int W = 256;
  localparam logic [W-1:0] P_WIDE =
    256'h8542D69E4C044F18E8B92435BF6FF7DE457283915C45517D722EDB8B08F1DFC3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b, p;
  logic         busy, done, err;
  logic [W-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  mod_mul_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .p(p),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(prod % {{W{1'b0}}, m});
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Starts a job, waits (bounded) for done, checks latency, busy span, result and err.
  task automatic do_job(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] tp);
    int lat, busy_cnt;
    logic [W-1:0] exp;
    exp = ref_mulmod(ta, tb_v, tp);
    @(negedge clk);
    a = ta; b = tb_v; p = tp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = rand_wide(); b = rand_wide(); p = rand_wide();
    lat = 1; busy_cnt = 0;
    while (!done && lat < 2 * W + 10) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, W'(lat), W'(W + 1));
    check({tag, " busy_span"}, W'(busy_cnt), W'(W));
    check({tag, " result"}, result, exp);
    check({tag, " err"}, W'(err), '0);
    @(negedge clk);
    check({tag, " done_pulse"}, W'(done), '0);
    check({tag, " result_hold"}, result, exp);
  endtask

  initial begin
    logic [W-1:0] rp, ra, rb, exp1;
    int lat, dcnt;
    rst_n = 1'b0; start = 1'b1; a = '0; b = '0; p = '0;
    repeat (3) @(negedge clk);
    check("rst busy", W'(busy), '0);
    check("rst done", W'(done), '0);
    check("rst result", result, '0);
    check("rst err", W'(err), '0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", W'(busy), '0);

    do_job("small", W'(5), W'(9), W'(11));
    do_job("wide_sq", P_WIDE - 1, P_WIDE - 1, P_WIDE);
    check("wide_sq literal", result, W'(1));
    do_job("wide_x2", P_WIDE - 1, W'(2), P_WIDE);
    check("wide_x2 literal", result, P_WIDE - 2);
    do_job("zero_a", '0, P_WIDE - 1, P_WIDE);
    do_job("zero_b", P_WIDE - 3, '0, P_WIDE);
    do_job("even_p", W'(7), W'(5), W'(10));

    for (int j = 0; j < 6; j++) begin
      rp = rand_wide();
      if (j == 1) rp = rp >> 200;
      if (rp < 2) rp = W'(2);
      ra = rand_wide() % rp;
      rb = rand_wide() % rp;
      do_job($sformatf("rand%0d", j), ra, rb, rp);
    end

    // Handshake: start during RUN ignored, start in DONE ignored, start after DONE accepted.
    exp1 = ref_mulmod(P_WIDE - 5, P_WIDE - 7, P_WIDE);
    @(negedge clk);
    a = P_WIDE - 5; b = P_WIDE - 7; p = P_WIDE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    a = W'(3); b = W'(4); p = W'(13); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 2 * W) begin
      @(negedge clk);
      lat++;
    end
    check("hs run_start_ignored", result, exp1);
    a = W'(6); b = W'(8); p = W'(17); start = 1'b1;
    @(negedge clk);
    check("hs done_start busy", W'(busy), '0);
    check("hs done_start done", W'(done), '0);
    a = W'(10); b = W'(12); p = W'(19);
    @(negedge clk);
    start = 1'b0;
    check("hs after_done accepted", W'(busy), W'(1));
    lat = 1;
    while (!done && lat < 2 * W) begin
      @(negedge clk);
      lat++;
    end
    check("hs after_done latency", W'(lat), W'(W + 1));
    check("hs after_done result", result, ref_mulmod(W'(10), W'(12), W'(19)));
    @(negedge clk);

    // Reset in the middle of a run.
    a = P_WIDE - 1; b = P_WIDE - 1; p = P_WIDE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    check("midrst busy", W'(busy), '0);
    check("midrst done", W'(done), '0);
    check("midrst result", result, '0);
    dcnt = 0;
    repeat (W + 20) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("midrst no_done", W'(dcnt), '0);
    do_job("after_rst", P_WIDE - 2, W'(3), P_WIDE);

`ifdef MODMUL_RANGE_CHECK_EN
    @(negedge clk);
    a = W'(11); b = W'(3); p = W'(11); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rc done", W'(done), W'(1));
    check("rc err", W'(err), W'(1));
    check("rc result", result, '0);
    check("rc busy", W'(busy), '0);
    @(negedge clk);
    check("rc err_held", W'(err), W'(1));
    do_job("rc valid", W'(4), W'(3), W'(11));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
